// File: rtl/sensor_nivel_filtro.sv
// -----------------------------------------------------------------------------
// sensor_nivel_filtro
//
// Conditioning stage for the tank level float switches.
//   - Each raw switch passes through a 2-flop synchroniser.
//   - Each synced bit is debounced independently: it must disagree with its
//     filtered value for DEB_CYCLES consecutive cycles before the filtered
//     value follows it.
//   - The filtered pattern {filt2,filt1,filt0} is checked for thermometer
//     consistency (000, 001, 011, 111).
//   - An inconsistent pattern moves the checker to SUSPEITO. In SUSPEITO the
//     outputs hold the last consistent pattern. If the pattern stays
//     inconsistent for FAULT_CYCLES cycles, the checker enters FALHA. In FALHA
//     the outputs are forced to 111 so that downstream logic closes the inlet.
//
// Configuration macro:
//   LEVEL_FAULT_HOLD_EN
//     - Defined:   FALHA is sticky. Only reset leaves it.
//     - Undefined: FALHA returns to OK on the first consistent filtered
//                  pattern.
//
// Parameters:
//   DEB_CYCLES    debounce length in cycles (>= 1)
//   FAULT_CYCLES  number of inconsistent cycles that raise a fault (>= 1)
//   CNT_W         counter width; 2**CNT_W >= max(DEB_CYCLES, FAULT_CYCLES)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   s_nv0..s_nv2  raw low/mid/high level switches (asynchronous)
//   Nv0..Nv2      conditioned levels
//   nivel_valido  1 while the checker is in OK
//   falha         1 while the checker is in FALHA
//   muda          one-cycle pulse in the cycle after Nv2..Nv0 change
// -----------------------------------------------------------------------------
module sensor_nivel_filtro #(
    parameter int DEB_CYCLES   = 8,
    parameter int FAULT_CYCLES = 16,
    parameter int CNT_W        = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic s_nv0,
    input  logic s_nv1,
    input  logic s_nv2,
    output logic Nv0,
    output logic Nv1,
    output logic Nv2,
    output logic nivel_valido,
    output logic falha,
    output logic muda
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] FC_LAST  = CNT_W'(FAULT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_SUSPEITO = 2'd1,
        ST_FALHA    = 2'd2
    } state_t;

    logic [2:0]       meta_reg;
    logic [2:0]       sync_reg;
    logic [2:0]       filt_reg;
    logic [2:0]       filt_next;
    logic [2:0]       last_reg;
    logic [CNT_W-1:0] fc_reg;
    state_t           state_reg;
    logic             pattern_ok;
    logic [2:0]       nv;
    logic [2:0]       nv_prev_reg;
    logic             muda_reg;

    // Two-flop synchroniser for all three switches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= 3'b000;
            sync_reg <= 3'b000;
        end else begin
            meta_reg <= {s_nv2, s_nv1, s_nv0};
            sync_reg <= meta_reg;
        end
    end

    // Per-bit debounce. The counter clears when the synced bit agrees with its
    // filtered value. It also clears on the cycle the filtered value takes the
    // new level, so the counter never saturates.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_reg;
            logic             differ;

            assign differ        = (sync_reg[gi] != filt_reg[gi]);
            assign filt_next[gi] = (differ && (cnt_reg == DEB_LAST)) ? sync_reg[gi]
                                                                     : filt_reg[gi];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                end else if (!differ || (cnt_reg == DEB_LAST)) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_reg <= 3'b111;
        end else begin
            filt_reg <= filt_next;
        end
    end

    // The checker evaluates the pattern that filt takes on this same edge, so
    // the state and the filtered bits change together. In OK, filt is
    // therefore always consistent, and a half-settled pattern never reaches
    // Nv, not even for one cycle.
    always_comb begin
        pattern_ok = (filt_next == 3'b000) || (filt_next == 3'b001) ||
                     (filt_next == 3'b011) || (filt_next == 3'b111);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_OK;
            fc_reg    <= '0;
            last_reg  <= 3'b111;
        end else begin
            case (state_reg)
                ST_OK: begin
                    if (pattern_ok) begin
                        last_reg <= filt_next;
                    end else begin
                        state_reg <= ST_SUSPEITO;
                        fc_reg    <= '0;
                    end
                end
                ST_SUSPEITO: begin
                    if (pattern_ok) begin
                        state_reg <= ST_OK;
                        last_reg  <= filt_next;
                    end else if (fc_reg == FC_LAST) begin
                        state_reg <= ST_FALHA;
                    end else begin
                        fc_reg <= fc_reg + CNT_W'(1);
                    end
                end
                ST_FALHA: begin
`ifdef LEVEL_FAULT_HOLD_EN
                    // Sticky fault: only reset leaves FALHA.
                    state_reg <= ST_FALHA;
`else
                    if (pattern_ok) begin
                        state_reg <= ST_OK;
                        last_reg  <= filt_next;
                    end
`endif
                end
                default: begin
                    state_reg <= ST_OK;
                end
            endcase
        end
    end

    // Level outputs decoded from the state.
    always_comb begin
        nv = 3'b111;
        case (state_reg)
            ST_OK:       nv = filt_reg;
            ST_SUSPEITO: nv = last_reg;
            default:     nv = 3'b111;
        endcase
    end

    // Change detector. Registered, so the pulse appears in the cycle after Nv
    // moves. It lasts exactly one cycle because nv_prev catches up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nv_prev_reg <= 3'b111;
            muda_reg    <= 1'b0;
        end else begin
            nv_prev_reg <= nv;
            muda_reg    <= (nv != nv_prev_reg);
        end
    end

    assign Nv0          = nv[0];
    assign Nv1          = nv[1];
    assign Nv2          = nv[2];
    assign nivel_valido = (state_reg == ST_OK);
    assign falha        = (state_reg == ST_FALHA);
    assign muda         = muda_reg;

endmodule
